mbscore_bus_responder: RTL and testbench
========================================

# mbscore_bus_responder

Memory-side responder for the MBScore multicycle core. It accepts the core's level-style access strobes (instruction fetch read, data read, data write) and converts each one into a single variable-latency req/ack transaction toward memory. While a transaction is outstanding it holds the core's `pause` input high, then returns the read data to the core. It sits between the control/datapath and the memory/bus fabric, clocked by `bus_clk`.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, `` `DATA_WIDTH `` (32): data word width.
- `TIMEOUT_CYCLES`, 255: cycles in REQ before a timeout abort; only used when `MBS_BUS_TIMEOUT_EN` is defined.
- `bus_clk`  in  1  the one clock; all logic on its posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_re`  in  1  core instruction-fetch strobe (level).
- `mem_re`  in  1  core data-read strobe (level).
- `mem_we`  in  1  core data-write strobe (level).
- `pc_addr`  in  ADDR_WIDTH  fetch address.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `pause`  out  1  core stall request.
- `ir_data`  out  DATA_WIDTH  last fetched instruction.
- `dr_data`  out  DATA_WIDTH  last loaded data word.
- `bus_err`  out  1  sticky timeout flag.
- `m_req`  out  1  memory request.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  ADDR_WIDTH  memory address.
- `m_wdata`  out  DATA_WIDTH  memory write data.
- `m_ack`  in  1  memory completion, single-cycle pulse.
- `m_rdata`  in  DATA_WIDTH  read data, valid when `m_ack` is high.

## Operation
- **FSM states:** IDLE, REQ, DONE.
- **Served flag.** One per strobe. It is set when that strobe's transaction completes and cleared on the first posedge the strobe is sampled low. A strobe is a *new request* only when it is high and its served flag is clear. Each strobe assertion therefore produces exactly one transaction, however long the core holds the level.
- **IDLE → REQ** on a new request.
  - Priority order: `mem_we` > `mem_re` > `inst_re`.
  - Capture type, address (`d_addr` or `pc_addr`) and `d_wdata` into registers.
  - `m_req` rises next cycle.
- **REQ:**
  - `m_req`=1; `m_we`, `m_addr`, `m_wdata` are driven from the captured registers and held stable.
  - On `m_ack` sampled high: load `m_rdata` into `ir_data` (fetch) or `dr_data` (data read); writes load nothing. Set the served flag, go to DONE.
- **DONE → IDLE** unconditionally; `m_req`=0.
- **Lower-priority strobes** that are high and not served remain pending and are taken from IDLE in a later transaction.
- **`pause`** is combinational: high when (IDLE and any new request present) or state is REQ; low in DONE and in IDLE with no new request.
- **Both `mem_re` and `mem_we` high:** write is performed, read is discarded. The read's served flag is set as well.

## Timing
- **Reset values:** state IDLE; all served flags 0; `m_req` 0, `m_we` 0, `m_addr` 0, `m_wdata` 0; `ir_data` 0, `dr_data` 0; `bus_err` 0; `pause` 0 (no strobes pending).
- **Latency.** Strobe seen at posedge T → `m_req` high from T+1. With `m_ack` at posedge T+k (k≥1), data registered at T+k, DONE in cycle T+k, `pause` low from T+k. Minimum strobe-to-data is 1 cycle of `m_req`, 2 cycles total.
- **Handshake:**
  - `m_req` is held with stable address and data until `m_ack` is sampled.
  - `m_req` drops in the cycle after ack (DONE).
  - `m_ack` while `m_req`=0 is ignored.
- **Reset mid-transaction:** immediate return to IDLE, `m_req` low, no data update. A late `m_ack` is ignored.

## Configuration
- **`MBS_BUS_TIMEOUT_EN` defined:**
  - An 8+ bit counter runs in REQ, cleared on entry.
  - At `TIMEOUT_CYCLES` without ack: go to DONE, set the served flag, load `ir_data`/`dr_data` with 0, and set `bus_err`.
  - `bus_err` clears only on reset.
- **Not defined:** no counter; REQ waits indefinitely and `bus_err` is tied 0.

## Structure
- **Shared package / `MBScore_const.v`:** state encodings (`BUS_IDLE`, `BUS_REQ`, `BUS_DONE`), access-type encoding (FETCH/LOAD/STORE), `DATA_WIDTH`.
- **One sub-module, `mbscore_strobe_tracker`:** served-flag and new-request logic for one strobe, instantiated three times.

## Test plan
- **Fetch:** `pc_addr`=0x0000_0040, `inst_re`=1 held 6 cycles, memory acks after 3 cycles with 0x2001_0005 → exactly one `m_req` pulse train (addr 0x40, `m_we`=0); `ir_data`=0x2001_0005; `pause` high 4 cycles, then low.
- **Store:** `mem_we`=1, `d_addr`=0x100, `d_wdata`=0xCAFE_F00D, ack after 1 cycle → `m_we`=1 with stable addr/data; `dr_data` unchanged.
- **Simultaneous strobes:** `mem_re` and `inst_re` together → load to 0x200 served first, then fetch; two transactions in that order.
- **Reset in REQ:** `rst_n` low for 1 cycle during REQ, then a late `m_ack` → `m_req`=0, `dr_data` unchanged, `pause`=0.
- **Timeout (with `MBS_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** no ack → DONE after 8 REQ cycles, `dr_data`=0, `bus_err`=1 and held.
- **Strobe re-arm:** `inst_re` toggles low for 1 cycle, then high → a second fetch is issued.

Source files
------------

// File: rtl/mbscore_bus_responder_pkg.sv
// Shared constants for the MBScore bus responder: state and access-type encodings, data width.
// DATA_WIDTH may be overridden by defining the DATA_WIDTH macro before this file.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mbscore_bus_responder_pkg;

    localparam int unsigned MBS_DATA_WIDTH = `DATA_WIDTH;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_DONE = 2'd2
    } bus_state_e;

    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_type_e;

endpackage

// File: rtl/mbscore_strobe_tracker.sv
// Served flag for one level-style core strobe; turns a held level into a single new-request.
module mbscore_strobe_tracker (
    input  logic bus_clk,
    input  logic rst_n,
    input  logic i_strobe,
    input  logic i_set_served,
    output logic o_new_req_c
);

    logic r_served;

    // Completion wins over a simultaneous low strobe; the flag then clears on the next low sample.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_served <= 1'b0;
        end else if (i_set_served) begin
            r_served <= 1'b1;
        end else if (!i_strobe) begin
            r_served <= 1'b0;
        end
    end

    assign o_new_req_c = i_strobe & ~r_served;

endmodule

// File: rtl/mbscore_bus_responder.sv
// Converts MBScore fetch/load/store strobes into single req/ack memory transactions and stalls the core.
// Optional timeout abort enabled by defining MBS_BUS_TIMEOUT_EN.
module mbscore_bus_responder
    import mbscore_bus_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = MBS_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  bus_clk,
    input  logic                  rst_n,
    input  logic                  inst_re,
    input  logic                  mem_re,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  pause,
    output logic [DATA_WIDTH-1:0] ir_data,
    output logic [DATA_WIDTH-1:0] dr_data,
    output logic                  bus_err,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ack,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    bus_state_e            r_state;
    bus_state_e            w_state_nxt;
    acc_type_e             r_acc;
    acc_type_e             w_acc_sel;
    logic                  r_rd_also;
    logic                  r_m_we;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0] r_m_wdata;
    logic [DATA_WIDTH-1:0] r_ir_data;
    logic [DATA_WIDTH-1:0] r_dr_data;
    logic [DATA_WIDTH-1:0] w_fin_data;
    logic                  w_we_new;
    logic                  w_re_new;
    logic                  w_ie_new;
    logic                  w_any_new;
    logic                  w_start;
    logic                  w_finish;
    logic                  w_timeout;
    logic                  w_set_we;
    logic                  w_set_re;
    logic                  w_set_ie;

    mbscore_strobe_tracker u_trk_we (
        .bus_clk      (bus_clk),
        .rst_n        (rst_n),
        .i_strobe     (mem_we),
        .i_set_served (w_set_we),
        .o_new_req_c  (w_we_new)
    );

    mbscore_strobe_tracker u_trk_re (
        .bus_clk      (bus_clk),
        .rst_n        (rst_n),
        .i_strobe     (mem_re),
        .i_set_served (w_set_re),
        .o_new_req_c  (w_re_new)
    );

    mbscore_strobe_tracker u_trk_ie (
        .bus_clk      (bus_clk),
        .rst_n        (rst_n),
        .i_strobe     (inst_re),
        .i_set_served (w_set_ie),
        .o_new_req_c  (w_ie_new)
    );

    assign w_any_new = w_we_new | w_re_new | w_ie_new;

    // A store issued while a read is also pending retires that read too.
    assign w_set_we = w_finish && (r_acc == ACC_STORE);
    assign w_set_re = w_finish && ((r_acc == ACC_LOAD) || ((r_acc == ACC_STORE) && r_rd_also));
    assign w_set_ie = w_finish && (r_acc == ACC_FETCH);

    // Next state, request selection by priority (store > load > fetch).
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        w_acc_sel   = ACC_FETCH;
        w_addr_sel  = pc_addr;
        if (w_we_new) begin
            w_acc_sel  = ACC_STORE;
            w_addr_sel = d_addr;
        end else if (w_re_new) begin
            w_acc_sel  = ACC_LOAD;
            w_addr_sel = d_addr;
        end
        case (r_state)
            BUS_IDLE: begin
                if (w_any_new) begin
                    w_start     = 1'b1;
                    w_state_nxt = BUS_REQ;
                end
            end
            BUS_REQ: begin
                if (m_ack || w_timeout) begin
                    w_finish    = 1'b1;
                    w_state_nxt = BUS_DONE;
                end
            end
            BUS_DONE: w_state_nxt = BUS_IDLE;
            default:  w_state_nxt = BUS_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the selected access; registers stay stable for the whole REQ phase.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= ACC_FETCH;
            r_rd_also <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else if (w_start) begin
            r_acc     <= w_acc_sel;
            r_rd_also <= w_we_new & w_re_new;
            r_m_we    <= (w_acc_sel == ACC_STORE);
            r_m_addr  <= w_addr_sel;
            r_m_wdata <= d_wdata;
        end
    end

    assign w_fin_data = w_timeout ? '0 : m_rdata;

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_data <= '0;
            r_dr_data <= '0;
        end else if (w_finish) begin
            case (r_acc)
                ACC_FETCH: r_ir_data <= w_fin_data;
                ACC_LOAD:  r_dr_data <= w_fin_data;
                default:   ;
            endcase
        end
    end

`ifdef MBS_BUS_TIMEOUT_EN
    localparam int unsigned TO_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_bus_err;

    // Counts REQ cycles; the abort fires on the last allowed cycle if no ack arrives.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_to_cnt <= '0;
            end else if (r_state == BUS_REQ) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == BUS_REQ) && !m_ack && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign bus_err   = r_bus_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
`endif

    assign pause   = ((r_state == BUS_IDLE) && w_any_new) || (r_state == BUS_REQ);
    assign m_req   = (r_state == BUS_REQ);
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign ir_data = r_ir_data;
    assign dr_data = r_dr_data;

endmodule

// File: tb/tb_mbscore_bus_responder.sv
// Scoreboard bench for mbscore_bus_responder: random strobe sets against a memory model with random latency.
module tb_mbscore_bus_responder;

    localparam int KIND_FETCH = 0;
    localparam int KIND_LOAD  = 1;
    localparam int KIND_STORE = 2;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          kind;
    } txn_t;

    logic        bus_clk;
    logic        rst_n;
    logic        inst_re, mem_re, mem_we;
    logic [31:0] pc_addr, d_addr, d_wdata;
    logic        pause;
    logic [31:0] ir_data, dr_data;
    logic        bus_err;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          pause_cnt = 0;
    txn_t        exp_q[$];
    logic [31:0] sh_ir = '0;
    logic [31:0] sh_dr = '0;
    logic        exp_bus_err = 1'b0;

    bit          mem_en = 1'b1;
    int          force_lat = -1;
    bit          force_data_en = 1'b0;
    logic [31:0] force_data = '0;

    mbscore_bus_responder #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .bus_clk (bus_clk),
        .rst_n   (rst_n),
        .inst_re (inst_re),
        .mem_re  (mem_re),
        .mem_we  (mem_we),
        .pc_addr (pc_addr),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .pause   (pause),
        .ir_data (ir_data),
        .dr_data (dr_data),
        .bus_err (bus_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    always @(negedge bus_clk) if (pause) pause_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Memory model: random (or forced) number of extra wait cycles, then a one-cycle ack.
    initial begin : memory
        int  lat;
        bit  in_txn;
        lat    = 0;
        in_txn = 1'b0;
        m_ack  = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge bus_clk);
            #2;
            if (mem_en) begin
                m_ack = 1'b0;
                if (m_req) begin
                    if (!in_txn) begin
                        in_txn = 1'b1;
                        lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                    end
                    if (lat == 0) begin
                        m_ack   = 1'b1;
                        m_rdata = force_data_en ? force_data : $urandom();
                        in_txn  = 1'b0;
                    end else begin
                        lat--;
                    end
                end
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    // Monitor: on every completing handshake pop the oldest expected access and check the result.
    initial begin : monitor
        txn_t        t;
        logic        prev_req;
        logic        prev_we;
        logic [31:0] prev_addr, prev_wdata;
        prev_req = 1'b0;
        prev_we = 1'b0;
        prev_addr = '0;
        prev_wdata = '0;
        forever begin
            @(negedge bus_clk);
            if (rst_n && m_req && prev_req) begin
                chk("addr_stable", m_addr, prev_addr);
                chk("we_stable", 32'(m_we), 32'(prev_we));
                chk("wdata_stable", m_wdata, prev_wdata);
            end
            prev_req = rst_n && m_req;
            prev_we = m_we;
            prev_addr = m_addr;
            prev_wdata = m_wdata;
            if (rst_n && m_req && m_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn", 32'(1), 32'(0));
                end else begin
                    t = exp_q.pop_front();
                    chk("txn_addr", m_addr, t.addr);
                    chk("txn_we", 32'(m_we), 32'(t.we));
                    if (t.we) chk("txn_wdata", m_wdata, t.wdata);
                    if (t.kind == KIND_FETCH) sh_ir = m_rdata;
                    if (t.kind == KIND_LOAD)  sh_dr = m_rdata;
                    @(negedge bus_clk);
                    chk("ir_data", ir_data, sh_ir);
                    chk("dr_data", dr_data, sh_dr);
                    chk("pause_done", 32'(pause), 32'(0));
                    chk("req_drop", 32'(m_req), 32'(0));
                    prev_req = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    // One core access: expected transactions follow from the priority and store-absorbs-load rules.
    task automatic do_op(input bit we, input bit re, input bit ie,
                         input logic [31:0] pa, input logic [31:0] da, input logic [31:0] wd,
                         input int low);
        int   n0, nexp, guard;
        txn_t t;
        n0 = done_cnt;
        nexp = 0;
        pc_addr = pa;
        d_addr = da;
        d_wdata = wd;
        if (we) begin
            t = '{we: 1'b1, addr: da, wdata: wd, kind: KIND_STORE};
            exp_q.push_back(t);
            nexp++;
        end
        if (re && !we) begin
            t = '{we: 1'b0, addr: da, wdata: '0, kind: KIND_LOAD};
            exp_q.push_back(t);
            nexp++;
        end
        if (ie) begin
            t = '{we: 1'b0, addr: pa, wdata: '0, kind: KIND_FETCH};
            exp_q.push_back(t);
            nexp++;
        end
        mem_we = we;
        mem_re = re;
        inst_re = ie;
        guard = 0;
        while (done_cnt < n0 + nexp && guard < 200) begin
            step();
            guard++;
        end
        chk("op_txn_count", 32'(done_cnt - n0), 32'(nexp));
        if (done_cnt < n0 + nexp) exp_q.delete();
        repeat ($urandom_range(1, 3)) step();
        mem_we = 1'b0;
        mem_re = 1'b0;
        inst_re = 1'b0;
        repeat (low) step();
    endtask

    initial begin : stim
        int p0, n, guard;
        bit got;
        logic [2:0] sel;
        rst_n = 1'b0;
        inst_re = 1'b0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        pc_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        chk("rst_m_req", 32'(m_req), 32'(0));
        chk("rst_m_we", 32'(m_we), 32'(0));
        chk("rst_m_addr", m_addr, 32'(0));
        chk("rst_m_wdata", m_wdata, 32'(0));
        chk("rst_ir", ir_data, 32'(0));
        chk("rst_dr", dr_data, 32'(0));
        chk("rst_bus_err", 32'(bus_err), 32'(0));
        chk("rst_pause", 32'(pause), 32'(0));

        // Reset during REQ followed by a stray ack.
        mem_en = 1'b0;
        m_ack = 1'b0;
        d_addr = 32'h0000_0300;
        mem_re = 1'b1;
        got = 1'b0;
        guard = 0;
        while (!got && guard < 10) begin
            step();
            got = m_req;
            guard++;
        end
        chk("rreq_seen", 32'(got), 32'(1));
        step();
        rst_n = 1'b0;
        mem_re = 1'b0;
        step();
        rst_n = 1'b1;
        m_rdata = 32'h1234_5678;
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        @(negedge bus_clk);
        chk("rreq_m_req", 32'(m_req), 32'(0));
        chk("rreq_dr", dr_data, 32'(0));
        chk("rreq_pause", 32'(pause), 32'(0));
        mem_en = 1'b1;
        step();

        // Fetch with three REQ cycles: pause must be high for exactly four cycles.
        force_lat = 2;
        force_data_en = 1'b1;
        force_data = 32'h2001_0005;
        p0 = pause_cnt;
        do_op(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 2);
        chk("fetch_pause_cycles", 32'(pause_cnt - p0), 32'(4));
        chk("fetch_ir", ir_data, 32'h2001_0005);

        // Store with single-cycle ack.
        force_lat = 0;
        force_data = 32'h5555_AAAA;
        do_op(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 32'hCAFE_F00D, 2);
        force_data_en = 1'b0;
        force_lat = -1;

        // Load and fetch together, then a fetch re-armed after one low cycle.
        do_op(1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0200, 32'h0, 1);
        do_op(1'b0, 1'b0, 1'b1, 32'h0000_0084, 32'h0, 32'h0, 1);
        do_op(1'b0, 1'b0, 1'b1, 32'h0000_0088, 32'h0, 32'h0, 2);

`ifdef MBS_BUS_TIMEOUT_EN
        mem_en = 1'b0;
        d_addr = 32'h0000_0400;
        mem_re = 1'b1;
        n = 0;
        guard = 0;
        while (guard < 100) begin
            @(negedge bus_clk);
            guard++;
            if (m_req) n++;
            else if (n > 0) break;
        end
        chk("to_req_cycles", 32'(n), 32'(8));
        step();
        chk("to_dr", dr_data, 32'(0));
        chk("to_bus_err", 32'(bus_err), 32'(1));
        sh_dr = '0;
        exp_bus_err = 1'b1;
        mem_re = 1'b0;
        mem_en = 1'b1;
        repeat (2) step();
`endif

        for (int i = 0; i < 40; i++) begin
            sel = 3'($urandom_range(1, 7));
            do_op(sel[2], sel[1], sel[0],
                  $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC, $urandom(),
                  $urandom_range(1, 3));
        end

        repeat (4) step();
        chk("final_bus_err", 32'(bus_err), 32'(exp_bus_err));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        chk("final_pause", 32'(pause), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
